l15_responder_model: RTL and testbench
======================================

Name: l15_responder_model

Overview:
- Synthesizable stand-in for the OpenPiton L1.5: the responder end of the l15_req_t / l15_rtrn_t interface driven by the core-side HPDC/I$ adapter.
- Used for tile-level simulation and FPGA bring-up of the Sargantana tile without a full OpenPiton chip.
- Accepts one request at a time and serves it from an internal 64-bit-word memory after a programmable latency.
- Returns OpenPiton-format load, ifill and store-ack packets.

Parameters:
- MemBase, 64'h0080000000, byte base address of backing memory
- MemWords, 4096, depth in 64-bit words (power of two)
- RespLatency, 4, cycles from request capture to first return beat (>=1)
- LoadBeats, 2, 256-bit return beats for a cacheable LOAD_RQ
- IfillBeats, 2, 256-bit return beats for an IMISS_RQ (512-bit I$ line)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- l15_req_i  in  $size(l15_req_t)  packed request from adapter (l15_val, l15_rqtype, l15_nc, l15_size, l15_threadid, l15_address, l15_data)
- l15_rtrn_o  out  $size(l15_rtrn_t)  packed return (l15_ack, l15_header_ack, l15_val, l15_returntype, l15_error, l15_noncacheable, l15_threadid, l15_data_0..3, l15_inval_*)
- l15_req_ack_i  in  1  adapter consumed current return beat (unpacked copy of l15_req_ack)
- busy_o  out  1  request in flight (state != IDLE)

Behaviour:
- Reset: every l15_rtrn_o field 0; busy_o=0; state IDLE; counters 0. Memory contents are not reset.
- FSM:
  - IDLE -> HDR when l15_val=1.
  - HDR: one cycle; l15_ack=l15_header_ack=1 (single-cycle pulse); capture rqtype, nc, size, threadid, address, data. -> WAIT.
  - WAIT: counter loads RespLatency-1 and decrements. At 0, perform the store write (if a store) and go to RESP.
  - RESP: drive beat; hold all fields stable while l15_val=1 until l15_req_ack_i=1. On ack, beat++. After last beat -> IDLE; l15_val drops the cycle after the final ack.
- Requester holds l15_val until header_ack. A new request is not sampled in HDR/WAIT/RESP, nor in the IDLE cycle immediately after the final ack (one bubble).
- Address map: word index = (addr - MemBase) >> 3, using [log2(MemWords)-1:0]. In range iff MemBase <= addr < MemBase + MemWords*8.
- LOAD_RQ, nc=0:
  - Line base = addr aligned to LoadBeats*32 B.
  - Beat k: data_j = mem[base + 4k + j], j=0..3.
  - returntype L15_LOAD_RET.
- LOAD_RQ, nc=1:
  - One beat; data_0 = data_1 = mem[addr>>3]; data_2 = data_3 = 0.
  - l15_noncacheable=1.
- IMISS_RQ: IfillBeats beats, aligned to IfillBeats*32 B; returntype L15_IFILL_RET.
- STORE_RQ:
  - Size 0/1/2/3 = 1/2/4/8 B. Byte lanes addr[2:0] .. addr[2:0]+2^size-1 are written from the same lanes of l15_data.
  - Misaligned or size>3: no write, l15_error=2'b11.
  - One beat, L15_ST_ACK, data fields 0.
- Out-of-range access: loads return zeros; stores are dropped. Both carry l15_error=2'b01 and the normal beat count.
- Any other rqtype: one beat L15_LOAD_RET, data 0, l15_error=2'b11.
- All beats echo the captured threadid.
- Reset mid-operation: immediate return to IDLE with outputs cleared; a pending store is not written if WAIT had not reached 0.

Optional Feature:
- L15_RESP_ICACHE_INVAL_EN
- Defined: the ST_ACK beat of every in-range successful store also sets:
  - l15_inval_icache_inval=1
  - l15_inval_address_15_4 = addr[15:4]
  - l15_inval_way=0
  This makes self-modifying code visible to the I$.
- Undefined: all l15_inval_* fields are tied to 0.

Test Plan:
- Store 8 B 64'hDEADBEEF_CAFEF00D to MemBase+8 (size 3), then nc load of the same address -> header_ack exactly 1 cycle after l15_val; ST_ACK beat RespLatency cycles after HDR; load returns data_0 = data_1 = 64'hDEADBEEF_CAFEF00D.
- Byte store 8'hA5 to MemBase+8+3 after the above, then reload -> 64'hDEADBEEF_A5FEF00D; words at MemBase+0 and MemBase+16 unchanged.
- Preload words 0..7 with values 0..7, IMISS_RQ at MemBase+24 -> 2 beats {0,1,2,3}, {4,5,6,7}. Holding l15_req_ack_i low for 5 cycles on beat 0 keeps it stable; no beat is lost.
- Load at MemBase-8 -> one LoadBeats response, all data zero, l15_error=2'b01. Store of size 3 at MemBase+4 -> ST_ACK with l15_error=2'b11, memory unchanged.
- Assert rst_ni low during WAIT of a store -> outputs 0 asynchronously, busy_o=0; the following load shows the old data.
- With L15_RESP_ICACHE_INVAL_EN, store to MemBase+16'h1230 -> ST_ACK has l15_inval_icache_inval=1, l15_inval_address_15_4=12'h123.

Source files
------------

// File: rtl/l15_responder_model.sv
// L1.5 responder stand-in: accepts one l15_req_t at a time and answers load, ifill and store-ack packets from a local memory.
// Optional: L15_RESP_ICACHE_INVAL_EN adds an I$ invalidation to the ST_ACK of every in-range successful store.
package l15_responder_pkg;
  localparam logic [4:0] L15_LOAD_RQ   = 5'b00000;
  localparam logic [4:0] L15_STORE_RQ  = 5'b00001;
  localparam logic [4:0] L15_IMISS_RQ  = 5'b10000;

  localparam logic [3:0] L15_LOAD_RET  = 4'b0000;
  localparam logic [3:0] L15_IFILL_RET = 4'b0001;
  localparam logic [3:0] L15_ST_ACK    = 4'b0100;

  localparam logic [1:0] L15_ERR_NONE  = 2'b00;
  localparam logic [1:0] L15_ERR_RANGE = 2'b01;
  localparam logic [1:0] L15_ERR_REQ   = 2'b11;

  typedef struct packed {
    logic        l15_val;
    logic [4:0]  l15_rqtype;
    logic        l15_nc;
    logic [2:0]  l15_size;
    logic [1:0]  l15_threadid;
    logic [39:0] l15_address;
    logic [63:0] l15_data;
  } l15_req_t;

  typedef struct packed {
    logic        l15_ack;
    logic        l15_header_ack;
    logic        l15_val;
    logic [3:0]  l15_returntype;
    logic [1:0]  l15_error;
    logic        l15_noncacheable;
    logic [1:0]  l15_threadid;
    logic [63:0] l15_data_0;
    logic [63:0] l15_data_1;
    logic [63:0] l15_data_2;
    logic [63:0] l15_data_3;
    logic        l15_inval_icache_all_way;
    logic        l15_inval_icache_inval;
    logic        l15_inval_dcache_all_way;
    logic        l15_inval_dcache_inval;
    logic [11:0] l15_inval_address_15_4;
    logic [1:0]  l15_inval_way;
  } l15_rtrn_t;
endpackage

module l15_responder_model
  import l15_responder_pkg::*;
#(
  parameter logic [63:0] MemBase     = 64'h0080000000,
  parameter int          MemWords    = 4096,
  parameter int          RespLatency = 4,
  parameter int          LoadBeats   = 2,
  parameter int          IfillBeats  = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  l15_req_t  l15_req_i,
  output l15_rtrn_t l15_rtrn_o,
  input  logic      l15_req_ack_i,
  output logic      busy_o
);

  localparam int AW = $clog2(MemWords);
  localparam int CW = $clog2(RespLatency + 1);
  localparam int BW = 8;

  typedef enum logic [1:0] {IDLE, HDR, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   beat_q;
  logic            bubble_q;

  logic [4:0]      rqtype_q;
  logic            nc_q;
  logic [2:0]      size_q;
  logic [1:0]      tid_q;
  logic [39:0]     addr_q;
  logic [63:0]     wdata_q;

  logic [63:0]     mem [MemWords];

  logic [63:0]     addr_full, offset;
  logic            in_range;
  logic [AW-1:0]   word_idx, line_mask, line_base, rd_base;
  logic [2:0]      lane, size_mask;
  logic [7:0]      be_base, be;
  logic            is_load, is_store, is_imiss, store_bad, last_beat, do_write;
  int              nbeats;

  // Decode of the captured request; everything downstream keys off these.
  always_comb begin
    addr_full = {24'h0, addr_q};
    offset    = addr_full - MemBase;
    in_range  = (addr_full >= MemBase) && (offset[63:AW+3] == '0);
    word_idx  = offset[AW+2:3];
    lane      = offset[2:0];
    is_load   = (rqtype_q == L15_LOAD_RQ);
    is_store  = (rqtype_q == L15_STORE_RQ);
    is_imiss  = (rqtype_q == L15_IMISS_RQ);

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    size_mask = 3'd0;
    be_base   = 8'h00;
    case (size_q)
      3'd0:    begin size_mask = 3'd0; be_base = 8'h01; end
      3'd1:    begin size_mask = 3'd1; be_base = 8'h03; end
      3'd2:    begin size_mask = 3'd3; be_base = 8'h0F; end
      3'd3:    begin size_mask = 3'd7; be_base = 8'hFF; end
      default: begin size_mask = 3'd0; be_base = 8'h00; end
    endcase
    store_bad = (size_q > 3'd3) || ((lane & size_mask) != 3'd0);
    be        = be_base << lane;

    nbeats = 1;
    if (is_load && !nc_q) nbeats = LoadBeats;
    else if (is_imiss)    nbeats = IfillBeats;
    last_beat = (beat_q == BW'(nbeats - 1));

    line_mask = is_imiss ? AW'(IfillBeats * 4 - 1) : AW'(LoadBeats * 4 - 1);
    line_base = word_idx & ~line_mask;
    rd_base   = line_base + (AW'(beat_q) << 2);

    do_write  = (state_q == WAIT) && (cnt_q == '0) && is_store && !store_bad && in_range;
  end

  // State register and request capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      bubble_q <= 1'b0;
      rqtype_q <= '0;
      nc_q     <= 1'b0;
      size_q   <= '0;
      tid_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state_q  <= state_d;
      bubble_q <= (state_q == RESP) && l15_req_ack_i && last_beat;
      case (state_q)
        HDR: begin
          rqtype_q <= l15_req_i.l15_rqtype;
          nc_q     <= l15_req_i.l15_nc;
          size_q   <= l15_req_i.l15_size;
          tid_q    <= l15_req_i.l15_threadid;
          addr_q   <= l15_req_i.l15_address;
          wdata_q  <= l15_req_i.l15_data;
          cnt_q    <= CW'(RespLatency - 1);
          beat_q   <= '0;
        end
        WAIT: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        RESP: if (l15_req_ack_i) beat_q <= beat_q + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the backing memory has no reset; a store only commits once WAIT reaches zero, so reset before that drops it.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Next-state logic; the bubble_q cycle ignores a still-asserted l15_val.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (l15_req_i.l15_val && !bubble_q) state_d = HDR;
      HDR:     state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (l15_req_ack_i && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: every field is a function of registered state, so a beat stays stable until acked.
  always_comb begin
    l15_rtrn_o = '0;
    case (state_q)
      HDR: begin
        l15_rtrn_o.l15_ack        = 1'b1;
        l15_rtrn_o.l15_header_ack = 1'b1;
      end
      RESP: begin
        l15_rtrn_o.l15_val      = 1'b1;
        l15_rtrn_o.l15_threadid = tid_q;
        if (is_load || is_imiss) begin
          l15_rtrn_o.l15_returntype   = is_imiss ? L15_IFILL_RET : L15_LOAD_RET;
          l15_rtrn_o.l15_noncacheable = is_load && nc_q;
          l15_rtrn_o.l15_error        = in_range ? L15_ERR_NONE : L15_ERR_RANGE;
          if (in_range) begin
            if (is_load && nc_q) begin
              l15_rtrn_o.l15_data_0 = mem[word_idx];
              l15_rtrn_o.l15_data_1 = mem[word_idx];
            end else begin
              l15_rtrn_o.l15_data_0 = mem[rd_base];
              l15_rtrn_o.l15_data_1 = mem[rd_base + AW'(1)];
              l15_rtrn_o.l15_data_2 = mem[rd_base + AW'(2)];
              l15_rtrn_o.l15_data_3 = mem[rd_base + AW'(3)];
            end
          end
        end else if (is_store) begin
          l15_rtrn_o.l15_returntype = L15_ST_ACK;
          if (store_bad)      l15_rtrn_o.l15_error = L15_ERR_REQ;
          else if (!in_range) l15_rtrn_o.l15_error = L15_ERR_RANGE;
`ifdef L15_RESP_ICACHE_INVAL_EN
          if (!store_bad && in_range) begin
            l15_rtrn_o.l15_inval_icache_inval = 1'b1;
            l15_rtrn_o.l15_inval_address_15_4 = addr_q[15:4];
            l15_rtrn_o.l15_inval_way          = 2'b00;
          end
`else
`endif
        end else begin
          l15_rtrn_o.l15_returntype = L15_LOAD_RET;
          l15_rtrn_o.l15_error      = L15_ERR_REQ;
        end
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_l15_responder_model.sv
// Scoreboard bench for l15_responder_model: expected beats are queued per request and compared as the DUT returns them.
module tb_l15_responder_model;
  import l15_responder_pkg::*;

  localparam logic [63:0] MEM_BASE = 64'h0080000000;
  localparam int          LAT      = 4;

  typedef struct packed {
    logic [3:0]   rt;
    logic [1:0]   err;
    logic         nc;
    logic [1:0]   tid;
    logic [255:0] data;
    logic         inv;
    logic [11:0]  ia;
  } beat_t;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  l15_req_t  req;
  l15_rtrn_t rtrn;
  logic      req_ack;
  logic      busy;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  l15_responder_model #(
    .MemBase(MEM_BASE), .MemWords(4096), .RespLatency(LAT), .LoadBeats(2), .IfillBeats(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .l15_req_i(req), .l15_rtrn_o(rtrn),
    .l15_req_ack_i(req_ack), .busy_o(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] a(input longint off);
    logic [63:0] full;
    full = MEM_BASE + 64'(off);
    return full[39:0];
  endfunction

  function automatic beat_t observed();
    beat_t b;
    b.rt   = rtrn.l15_returntype;
    b.err  = rtrn.l15_error;
    b.nc   = rtrn.l15_noncacheable;
    b.tid  = rtrn.l15_threadid;
    b.data = {rtrn.l15_data_3, rtrn.l15_data_2, rtrn.l15_data_1, rtrn.l15_data_0};
    b.inv  = rtrn.l15_inval_icache_inval;
    b.ia   = rtrn.l15_inval_address_15_4;
    return b;
  endfunction

  task automatic push(input logic [3:0] rt, input logic [1:0] err, input logic nc, input logic [1:0] tid,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    beat_t b;
    b.rt = rt; b.err = err; b.nc = nc; b.tid = tid;
    b.data = {d3, d2, d1, d0};
    b.inv = 1'b0; b.ia = 12'h000;
    sb.push_back(b);
  endtask

  task automatic push_st(input logic [39:0] addr, input logic [1:0] err, input logic [1:0] tid);
    beat_t b;
    b.rt = L15_ST_ACK; b.err = err; b.nc = 1'b0; b.tid = tid; b.data = '0;
    b.inv = 1'b0; b.ia = 12'h000;
`ifdef L15_RESP_ICACHE_INVAL_EN
    if (err == L15_ERR_NONE) begin
      b.inv = 1'b1;
      b.ia  = addr[15:4];
    end
`else
`endif
    sb.push_back(b);
  endtask

  // Issue one request and retire every queued beat; hold stalls the ack of the first beat.
  task automatic run_req(input string name, input logic [4:0] rq, input logic nc, input logic [2:0] sz,
                         input logic [1:0] tid, input logic [39:0] addr, input logic [63:0] d, input int hold);
    int    n;
    int    w;
    int    hold_left;
    beat_t e;
    beat_t g;
    req.l15_val = 1'b1; req.l15_rqtype = rq; req.l15_nc = nc; req.l15_size = sz;
    req.l15_threadid = tid; req.l15_address = addr; req.l15_data = d;
    n = 0;
    do begin cyc(); n++; end while (rtrn.l15_header_ack !== 1'b1 && n < 20);
    total++;
    if (rtrn.l15_header_ack !== 1'b1 || rtrn.l15_ack !== 1'b1 || busy !== 1'b1 || n != 1) begin
      bad++;
      $display("FAIL %s header: ack=%b header_ack=%b busy=%b after %0d cycles, need 1/1/1 after 1",
               name, rtrn.l15_ack, rtrn.l15_header_ack, busy, n);
    end
    req.l15_val = 1'b0;
    w = 0;
    cyc();
    while (rtrn.l15_val !== 1'b1 && w < 50) begin w++; cyc(); end
    total++;
    if (w != LAT) begin
      bad++;
      $display("FAIL %s latency: %0d wait cycles, need %0d", name, w, LAT);
    end
    hold_left = hold;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rtrn.l15_val !== 1'b1) begin
        bad++;
        $display("FAIL %s beat missing: l15_val=%b, need 1 (%0d beats left)", name, rtrn.l15_val, sb.size() + 1);
        sb.delete();
        break;
      end
      g = observed();
      if (g !== e) begin
        bad++;
        $display("FAIL %s beat: got rt=%h err=%h nc=%b tid=%h inv=%b ia=%h data=%h, need rt=%h err=%h nc=%b tid=%h inv=%b ia=%h data=%h",
                 name, g.rt, g.err, g.nc, g.tid, g.inv, g.ia, g.data, e.rt, e.err, e.nc, e.tid, e.inv, e.ia, e.data);
      end
      if (hold_left > 0) begin
        for (int h = 0; h < hold_left; h++) cyc();
        hold_left = 0;
        g = observed();
        total++;
        if (rtrn.l15_val !== 1'b1 || g !== e) begin
          bad++;
          $display("FAIL %s held beat: val=%b data=%h, need val=1 data=%h", name, rtrn.l15_val, g.data, e.data);
        end
      end
      req_ack = 1'b1;
      cyc();
      req_ack = 1'b0;
    end
    total++;
    if (rtrn.l15_val !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end: val=%b busy=%b, need 0/0", name, rtrn.l15_val, busy);
    end
    cyc();
  endtask

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      push_st(a(8 * i), L15_ERR_NONE, 2'd0);
      run_req("preload", L15_STORE_RQ, 1'b0, 3'd3, 2'd0, a(8 * i), 64'(i), 0);
    end
  endtask

  task automatic test_reset();
    req = '0; req_ack = 1'b0; rst_n = 1'b0;
    cyc(); cyc();
    total++;
    if (rtrn !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rtrn=%h busy=%b, need 0/0", rtrn, busy);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_store_load();
    preload();
    push_st(a(8), L15_ERR_NONE, 2'd1);
    run_req("store8", L15_STORE_RQ, 1'b0, 3'd3, 2'd1, a(8), 64'hDEADBEEF_CAFEF00D, 0);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd2, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D, 64'h0, 64'h0);
    run_req("nc_load8", L15_LOAD_RQ, 1'b1, 3'd3, 2'd2, a(8), 64'h0, 0);
  endtask

  task automatic test_byte_store();
    push_st(a(11), L15_ERR_NONE, 2'd3);
    run_req("store1", L15_STORE_RQ, 1'b0, 3'd0, 2'd3, a(11), 64'hA5A5A5A5_A5A5A5A5, 0);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd0, 64'hDEADBEEF_A5FEF00D, 64'hDEADBEEF_A5FEF00D, 64'h0, 64'h0);
    run_req("reload8", L15_LOAD_RQ, 1'b1, 3'd3, 2'd0, a(8), 64'h0, 0);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    run_req("neighbour0", L15_LOAD_RQ, 1'b1, 3'd3, 2'd0, a(0), 64'h0, 0);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd0, 64'h2, 64'h2, 64'h0, 64'h0);
    run_req("neighbour16", L15_LOAD_RQ, 1'b1, 3'd3, 2'd0, a(16), 64'h0, 0);
  endtask

  task automatic test_reset_mid_store();
    int n;
    req.l15_val = 1'b1; req.l15_rqtype = L15_STORE_RQ; req.l15_nc = 1'b0; req.l15_size = 3'd3;
    req.l15_threadid = 2'd1; req.l15_address = a(8); req.l15_data = 64'h11111111_22222222;
    n = 0;
    do begin cyc(); n++; end while (rtrn.l15_header_ack !== 1'b1 && n < 20);
    req.l15_val = 1'b0;
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rtrn !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_wait: rtrn=%h busy=%b, need 0/0", rtrn, busy);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd1, 64'hDEADBEEF_A5FEF00D, 64'hDEADBEEF_A5FEF00D, 64'h0, 64'h0);
    run_req("after_reset", L15_LOAD_RQ, 1'b1, 3'd3, 2'd1, a(8), 64'h0, 0);
  endtask

  task automatic test_ifill();
    preload();
    push(L15_IFILL_RET, L15_ERR_NONE, 1'b0, 2'd2, 64'd0, 64'd1, 64'd2, 64'd3);
    push(L15_IFILL_RET, L15_ERR_NONE, 1'b0, 2'd2, 64'd4, 64'd5, 64'd6, 64'd7);
    run_req("imiss24", L15_IMISS_RQ, 1'b0, 3'd0, 2'd2, a(24), 64'h0, 5);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b0, 2'd3, 64'd0, 64'd1, 64'd2, 64'd3);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b0, 2'd3, 64'd4, 64'd5, 64'd6, 64'd7);
    run_req("load40", L15_LOAD_RQ, 1'b0, 3'd3, 2'd3, a(40), 64'h0, 0);
  endtask

  task automatic test_errors();
    push(L15_LOAD_RET, L15_ERR_RANGE, 1'b0, 2'd1, 64'h0, 64'h0, 64'h0, 64'h0);
    push(L15_LOAD_RET, L15_ERR_RANGE, 1'b0, 2'd1, 64'h0, 64'h0, 64'h0, 64'h0);
    run_req("load_below", L15_LOAD_RQ, 1'b0, 3'd3, 2'd1, a(-8), 64'h0, 0);
    push_st(a(4), L15_ERR_REQ, 2'd0);
    run_req("misaligned", L15_STORE_RQ, 1'b0, 3'd3, 2'd0, a(4), 64'hFFFFFFFF_FFFFFFFF, 0);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd0, 64'h0, 64'h0, 64'h0, 64'h0);
    run_req("unchanged0", L15_LOAD_RQ, 1'b1, 3'd3, 2'd0, a(0), 64'h0, 0);
    push_st(a(32768), L15_ERR_RANGE, 2'd2);
    run_req("store_above", L15_STORE_RQ, 1'b0, 3'd3, 2'd2, a(32768), 64'h5, 0);
    push(L15_LOAD_RET, L15_ERR_REQ, 1'b0, 2'd3, 64'h0, 64'h0, 64'h0, 64'h0);
    run_req("bad_rqtype", 5'b00111, 1'b0, 3'd3, 2'd3, a(0), 64'h0, 0);
  endtask

  task automatic test_inval();
    push_st(a(32'h1230), L15_ERR_NONE, 2'd1);
    run_req("store1230", L15_STORE_RQ, 1'b0, 3'd3, 2'd1, a(32'h1230), 64'h01234567_89ABCDEF, 0);
    push(L15_LOAD_RET, L15_ERR_NONE, 1'b1, 2'd1, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, 64'h0, 64'h0);
    run_req("load1230", L15_LOAD_RQ, 1'b1, 3'd3, 2'd1, a(32'h1230), 64'h0, 0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_reset_mid_store();
    test_ifill();
    test_errors();
    test_inval();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
